// File: rtl/tensor_core_pkg.sv
// Shared widths, element and matrix types, and the collector state encoding for the tensor core slice.
package tensor_core_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ACC_WIDTH  = 18;
  localparam int ADDR_WIDTH = 8;
  localparam int ELEM_COUNT = 9;
  localparam int LAST_PAIR  = 4;

  typedef logic signed [DATA_WIDTH-1:0] element_t;
  typedef element_t matrix_t [3][3];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITEBACK,
    ST_DONE
  } collector_state_e;

  // Row-major lookup; an index past the last element reads as zero.
  function automatic element_t matrix_elem(matrix_t m, logic [3:0] idx);
    element_t e;
    e = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (4'(r * 3 + c) == idx) e = m[r][c];
    return e;
  endfunction
endpackage

// File: rtl/tensor_result_collector_if.sv
// Element stream from the tensor core plus the two-lane register-file write port.
interface tensor_result_collector_if;
  import tensor_core_pkg::*;

  logic                             element_valid_in;
  logic signed [ACC_WIDTH-1:0]      element_data_in;
  logic [1:0]                       write_enable_out;
  logic [1:0][ADDR_WIDTH-1:0]       write_address_out;
  element_t [1:0]                   write_data_out;
  logic                             write_ready_in;

  modport slave (
    input  element_valid_in, element_data_in, write_ready_in,
    output write_enable_out, write_address_out, write_data_out
  );

  modport master (
    output element_valid_in, element_data_in, write_ready_in,
    input  write_enable_out, write_address_out, write_data_out
  );
endinterface

// File: rtl/tensor_element_narrow.sv
// Combinational ACC_WIDTH -> DATA_WIDTH element converter.
// TENSOR_RESULT_COLLECTOR_SATURATE_EN selects signed clamping; otherwise two's-complement truncation.
module tensor_element_narrow
  import tensor_core_pkg::*;
(
  input  logic signed [ACC_WIDTH-1:0] acc_in,
  output element_t                    element_out
);

`ifdef TENSOR_RESULT_COLLECTOR_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] MAX_VAL =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_VAL =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    element_out = acc_in[DATA_WIDTH-1:0];
    if (acc_in > MAX_VAL)      element_out = MAX_VAL[DATA_WIDTH-1:0];
    else if (acc_in < MIN_VAL) element_out = MIN_VAL[DATA_WIDTH-1:0];
  end
`else
  assign element_out = acc_in[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/tensor_result_collector.sv
// Collects nine row-major tensor core results into a 3x3 matrix and writes them back in lane pairs.
// Narrowing mode follows TENSOR_RESULT_COLLECTOR_SATURATE_EN (see tensor_element_narrow).
//
// state        | meaning
// ST_IDLE      | waiting for start_in
// ST_COLLECT   | accepting elements 0..8 into the buffer
// ST_WRITEBACK | presenting write pairs 0..4, advancing on write_ready_in
// ST_DONE      | single-cycle completion pulse
module tensor_result_collector
  import tensor_core_pkg::*;
(
  input  logic                      clock_in,
  input  logic                      reset_in,
  input  logic                      start_in,
  input  logic [ADDR_WIDTH-1:0]     dest_base_addr_in,
  tensor_result_collector_if.slave  bus,
  output matrix_t                   result_matrix_out,
  output logic                      result_valid_out,
  output logic                      busy_out,
  output logic                      done_out,
  output logic                      overflow_error_out
);

  collector_state_e            state_q, state_nxt;
  logic [3:0]                  count_q, count_nxt;
  logic [2:0]                  pair_q, pair_nxt;
  logic [ADDR_WIDTH-1:0]       base_q, base_nxt;
  matrix_t                     buf_q, buf_nxt;
  logic                        rv_q, rv_nxt;
  logic                        ovf_q, ovf_nxt;
  logic [1:0]                  we_q, we_nxt;
  logic [1:0][ADDR_WIDTH-1:0]  wa_q, wa_nxt;
  element_t [1:0]              wd_q, wd_nxt;
  element_t                    elem_narrow;

  tensor_element_narrow u_narrow (
    .acc_in      (bus.element_data_in),
    .element_out (elem_narrow)
  );

  always_comb begin
    state_nxt = state_q;
    count_nxt = count_q;
    pair_nxt  = pair_q;
    base_nxt  = base_q;
    buf_nxt   = buf_q;
    rv_nxt    = rv_q;
    ovf_nxt   = ovf_q;
    we_nxt    = we_q;
    wa_nxt    = wa_q;
    wd_nxt    = wd_q;

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          base_nxt  = dest_base_addr_in;
          count_nxt = '0;
          rv_nxt    = 1'b0;
          ovf_nxt   = 1'b0;
          state_nxt = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (bus.element_valid_in) begin
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              if (4'(r * 3 + c) == count_q) buf_nxt[r][c] = elem_narrow;
          count_nxt = count_q + 4'd1;
          // Pair 0 only needs elements 0 and 1, which are already buffered.
          if (count_q == 4'(ELEM_COUNT - 1)) begin
            state_nxt = ST_WRITEBACK;
            rv_nxt    = 1'b1;
            pair_nxt  = '0;
            we_nxt    = 2'b11;
            wa_nxt[0] = base_q;
            wa_nxt[1] = base_q + ADDR_WIDTH'(1);
            wd_nxt[0] = matrix_elem(buf_q, 4'd0);
            wd_nxt[1] = matrix_elem(buf_q, 4'd1);
          end
        end
      end
      ST_WRITEBACK: begin
        if (bus.write_ready_in) begin
          if (pair_q == 3'(LAST_PAIR)) begin
            state_nxt = ST_DONE;
            we_nxt    = '0;
            wa_nxt    = '0;
            wd_nxt    = '0;
          end else begin
            pair_nxt  = pair_q + 3'd1;
            we_nxt    = (pair_nxt == 3'(LAST_PAIR)) ? 2'b01 : 2'b11;
            wa_nxt[0] = base_q + ADDR_WIDTH'({pair_nxt, 1'b0});
            wa_nxt[1] = base_q + ADDR_WIDTH'({pair_nxt, 1'b1});
            wd_nxt[0] = matrix_elem(buf_q, {pair_nxt, 1'b0});
            wd_nxt[1] = matrix_elem(buf_q, {pair_nxt, 1'b1});
          end
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase

    // A stray element outside collection is dropped but remembered.
    if (bus.element_valid_in && state_q != ST_COLLECT) ovf_nxt = 1'b1;
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      pair_q  <= '0;
      base_q  <= '0;
      buf_q   <= '{default: '0};
      rv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      we_q    <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_nxt;
      count_q <= count_nxt;
      pair_q  <= pair_nxt;
      base_q  <= base_nxt;
      buf_q   <= buf_nxt;
      rv_q    <= rv_nxt;
      ovf_q   <= ovf_nxt;
      we_q    <= we_nxt;
      wa_q    <= wa_nxt;
      wd_q    <= wd_nxt;
    end
  end

  assign bus.write_enable_out  = we_q;
  assign bus.write_address_out = wa_q;
  assign bus.write_data_out    = wd_q;
  assign result_matrix_out     = buf_q;
  assign result_valid_out      = rv_q;
  assign overflow_error_out    = ovf_q;
  assign busy_out              = (state_q != ST_IDLE);
  assign done_out              = (state_q == ST_DONE);

endmodule

// File: tb/tb_tensor_result_collector.sv
// Self-checking bench for tensor_result_collector: narrowing table, directed corner sequences, random runs.
module tb_tensor_result_collector;
  import tensor_core_pkg::*;

  logic                  clock_in = 1'b0;
  logic                  reset_in;
  logic                  start_in;
  logic [ADDR_WIDTH-1:0] dest_base_addr_in;
  matrix_t               result_matrix;
  logic                  result_valid, busy, done, overflow;

  tensor_result_collector_if bus ();

  tensor_result_collector dut (
    .clock_in           (clock_in),
    .reset_in           (reset_in),
    .start_in           (start_in),
    .dest_base_addr_in  (dest_base_addr_in),
    .bus                (bus),
    .result_matrix_out  (result_matrix),
    .result_valid_out   (result_valid),
    .busy_out           (busy),
    .done_out           (done),
    .overflow_error_out (overflow)
  );

  always #5 clock_in = ~clock_in;

  int checks = 0;
  int errors = 0;
  int obs_addr[$];
  int obs_data[$];
  int en_cycles;
  int done_cnt;

  typedef struct {
    int value;
    int exp_trunc;
    int exp_sat;
  } narrow_vec_t;
  narrow_vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  // Reference narrowing from the numeric rule, not from bit slicing.
  function automatic int model_narrow(input int v);
`ifdef TENSOR_RESULT_COLLECTOR_SATURATE_EN
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
`else
    int m;
    m = ((v % 256) + 256) % 256;
    return (m > 127) ? m - 256 : m;
`endif
  endfunction

  // Write-port monitor: records handshakes and checks that stalled pairs hold still.
  initial begin
    logic       hold;
    logic [1:0] h_we;
    logic [1:0][ADDR_WIDTH-1:0] h_wa;
    logic [2*DATA_WIDTH-1:0]    h_wd;
    hold = 1'b0;
    h_we = '0;
    h_wa = '0;
    h_wd = '0;
    forever begin
      @(negedge clock_in);
      if (reset_in) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_enable", int'(bus.write_enable_out), int'(h_we));
          check("hold_address", int'(bus.write_address_out), int'(h_wa));
          check("hold_data", int'(bus.write_data_out), int'(h_wd));
        end
        if (bus.write_enable_out != 2'b00) begin
          en_cycles++;
          if (bus.write_ready_in) begin
            for (int l = 0; l < 2; l++) begin
              if (bus.write_enable_out[l]) begin
                obs_addr.push_back(int'(bus.write_address_out[l]));
                obs_data.push_back(int'($signed(bus.write_data_out[l])));
              end
            end
          end
        end
        hold = (bus.write_enable_out != 2'b00) && !bus.write_ready_in;
        h_we = bus.write_enable_out;
        h_wa = bus.write_address_out;
        h_wd = bus.write_data_out;
        if (done) done_cnt++;
      end
    end
  end

  // ready_mode: 0 = always ready, 1 = random, 2 = three stall cycles on pair 1.
  task automatic run_matrix(input logic [ADDR_WIDTH-1:0] base, input int e[9],
                            input int gap_idx, input int gap_len, input int gap_pct,
                            input int ready_mode, input bit poke_wb);
    int n;
    int stall_left;
    int gaps;
    obs_addr.delete();
    obs_data.delete();
    en_cycles = 0;
    done_cnt  = 0;
    bus.write_ready_in = 1'b1;
    dest_base_addr_in = base;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    dest_base_addr_in = '0;
    check("busy_after_start", int'(busy), 1);
    check("ovf_cleared_by_start", int'(overflow), 0);
    check("rv_cleared_by_start", int'(result_valid), 0);
    for (int i = 0; i < 9; i++) begin
      gaps = (i == gap_idx) ? gap_len : 0;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) gaps += $urandom_range(3, 1);
      bus.element_valid_in = 1'b0;
      repeat (gaps) tick();
      bus.element_valid_in = 1'b1;
      bus.element_data_in  = 18'(e[i]);
      tick();
    end
    bus.element_valid_in = 1'b0;
    check("first_pair_enable", int'(bus.write_enable_out), 3);
    check("first_pair_addr0", int'(bus.write_address_out[0]), int'(base));
    check("rv_at_writeback", int'(result_valid), 1);

    n = 0;
    stall_left = (ready_mode == 2) ? 3 : 0;
    while (busy && n < 300) begin
      case (ready_mode)
        1: bus.write_ready_in = 1'($urandom_range(1));
        2: begin
          if (stall_left > 0 && bus.write_enable_out != 2'b00 &&
              bus.write_address_out[0] == base + 8'd2) begin
            bus.write_ready_in = 1'b0;
            stall_left--;
          end else begin
            bus.write_ready_in = 1'b1;
          end
        end
        default: bus.write_ready_in = 1'b1;
      endcase
      if (poke_wb && n == 1) begin
        start_in = 1'b1;
        dest_base_addr_in = base ^ 8'h80;
        bus.element_valid_in = 1'b1;
        bus.element_data_in  = 18'd99;
      end else begin
        start_in = 1'b0;
        bus.element_valid_in = 1'b0;
      end
      tick();
      n++;
    end
    start_in = 1'b0;
    bus.element_valid_in = 1'b0;
    bus.write_ready_in = 1'b1;
    check("writeback_finished", int'(n < 300), 1);

    check("write_count", obs_addr.size(), 9);
    for (int i = 0; i < 9 && i < obs_addr.size(); i++) begin
      check("write_addr", obs_addr[i], (int'(base) + i) % 256);
      check("write_data", obs_data[i], model_narrow(e[i]));
    end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        check("matrix", int'(result_matrix[r][c]), model_narrow(e[r * 3 + c]));
    check("done_pulses", done_cnt, 1);
    check("rv_held", int'(result_valid), 1);
    check("idle_after_done", int'(busy), 0);
    check("enable_off_after", int'(bus.write_enable_out), 0);
    check("overflow_after", int'(overflow), poke_wb ? 1 : 0);
  endtask

  initial begin
    int e[9];
    int any_nz;

    vecs[0] = '{300, 44, 127};
    vecs[1] = '{-200, 56, -128};
    vecs[2] = '{127, 127, 127};
    vecs[3] = '{-128, -128, -128};
    vecs[4] = '{128, -128, 127};
    vecs[5] = '{-129, 127, -128};
    vecs[6] = '{0, 0, 0};
    vecs[7] = '{131071, -1, 127};
    vecs[8] = '{-131072, 0, -128};

    reset_in = 1'b1;
    start_in = 1'b0;
    dest_base_addr_in = '0;
    bus.element_valid_in = 1'b0;
    bus.element_data_in  = '0;
    bus.write_ready_in   = 1'b1;
    repeat (3) tick();
    any_nz = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (result_matrix[r][c] != 0) any_nz = 1;
    check("reset_matrix", any_nz, 0);
    check("reset_enable", int'(bus.write_enable_out), 0);
    check("reset_address", int'(bus.write_address_out), 0);
    check("reset_data", int'(bus.write_data_out), 0);
    check("reset_rv", int'(result_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_ovf", int'(overflow), 0);
    reset_in = 1'b0;
    tick();

    // Basic run, ready tied high: five writeback cycles.
    for (int i = 0; i < 9; i++) e[i] = i + 1;
    run_matrix(8'h10, e, -1, 0, 0, 0, 1'b0);
    check("basic_wb_cycles", en_cycles, 5);
    for (int i = 0; i < 9; i++) check("basic_matrix", int'(result_matrix[i / 3][i % 3]), i + 1);
    if (obs_addr.size() == 9) begin
      check("basic_last_addr", obs_addr[8], 8'h18);
      check("basic_last_data", obs_data[8], 9);
    end

    // Backpressure on pair 1.
    run_matrix(8'h10, e, -1, 0, 0, 2, 1'b0);
    check("stall_wb_cycles", en_cycles, 8);

    // Narrowing table.
    for (int i = 0; i < 9; i++) e[i] = vecs[i].value;
    run_matrix(8'h30, e, -1, 0, 0, 0, 1'b0);
    for (int i = 0; i < 9; i++) begin
`ifdef TENSOR_RESULT_COLLECTOR_SATURATE_EN
      check("narrow_table", int'(result_matrix[i / 3][i % 3]), vecs[i].exp_sat);
`else
      check("narrow_table", int'(result_matrix[i / 3][i % 3]), vecs[i].exp_trunc);
`endif
    end

    // Address wrap.
    for (int i = 0; i < 9; i++) e[i] = i * 3 - 10;
    run_matrix(8'hFE, e, -1, 0, 0, 0, 1'b0);
    if (obs_addr.size() == 9) begin
      check("wrap_pair1_lane0", obs_addr[2], 0);
      check("wrap_pair1_lane1", obs_addr[3], 1);
    end

    // Valid gaps between elements 3 and 4.
    for (int i = 0; i < 9; i++) e[i] = i * 7 - 20;
    run_matrix(8'h50, e, 4, 4, 0, 0, 1'b0);

    // Reset after element 5.
    dest_base_addr_in = 8'h60;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.element_valid_in = 1'b1;
      bus.element_data_in  = 18'(i + 11);
      tick();
    end
    bus.element_valid_in = 1'b0;
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    any_nz = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (result_matrix[r][c] != 0) any_nz = 1;
    check("midreset_matrix", any_nz, 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_rv", int'(result_valid), 0);
    check("midreset_enable", int'(bus.write_enable_out), 0);
    obs_addr.delete();
    obs_data.delete();
    repeat (10) tick();
    check("midreset_no_writes", obs_addr.size(), 0);
    check("midreset_stays_idle", int'(busy), 0);

    // Element in IDLE is an error; the following start clears it.
    bus.element_valid_in = 1'b1;
    bus.element_data_in  = 18'd5;
    tick();
    bus.element_valid_in = 1'b0;
    check("idle_elem_ovf", int'(overflow), 1);
    check("idle_elem_stays_idle", int'(busy), 0);
    for (int i = 0; i < 9; i++) e[i] = 40 - i * 9;
    run_matrix(8'h40, e, -1, 0, 0, 0, 1'b1);

    // Randomised runs against the reference model.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 9; i++) begin
        if ($urandom_range(2) == 0) e[i] = int'($urandom_range(262143)) - 131072;
        else                        e[i] = int'($urandom_range(400)) - 200;
      end
      run_matrix(8'($urandom_range(255)), e, -1, 0, 30, 1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
